keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_debounce.sv | 71 +++++++
 rtl/keypad_scanner.sv | 96 +++++++++
 tb/tb_keypad_scanner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared matrix geometry and key-code helper for the keypad scanner slice.
package keypad_pkg;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int KEYS       = ROWS * COLS;
  localparam int KEY_CODE_W = 4;

  function automatic logic [KEY_CODE_W-1:0] key_code_of(input logic [1:0] row,
                                                        input logic [1:0] col);
    return KEY_CODE_W'(row * COLS + col);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: stability counter, debounced key_state and
// new-press candidate selection (lowest index wins, others reported as lost).
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_done,
  input  logic [KEYS-1:0]       snapshot,
  output logic [KEYS-1:0]       key_state,
  output logic                  cand_vld,
  output logic [KEY_CODE_W-1:0] cand_code,
  output logic                  cand_multi
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

  logic [KEYS-1:0] prev_frame;
  logic [3:0]      stab_cnt;
  logic [3:0]      cnt_nxt;
  logic            frame_eq;
  logic [KEYS-1:0] newp_p1;
  logic            vld_p1;
  logic [KEYS-1:0] newp_rest;

  function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [KEYS-1:0] set);
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (set[i]) code = key_code_of(2'(i / COLS), 2'(i % COLS));
    end
    return code;
  endfunction

  always_comb begin
    frame_eq = (snapshot == prev_frame);
    cnt_nxt  = 4'd1;
    if (frame_eq) cnt_nxt = (stab_cnt == DEB_MAX) ? stab_cnt : stab_cnt + 4'd1;
  end

  // Stage p0 -> p1: frame compare, debounced state update, new-press capture
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_frame <= '0;
      stab_cnt   <= '0;
      key_state  <= '0;
      newp_p1    <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (frame_done) begin
        prev_frame <= snapshot;
        stab_cnt   <= cnt_nxt;
        if (cnt_nxt == DEB_MAX && snapshot != key_state) begin
          key_state <= snapshot;
          newp_p1   <= snapshot & ~key_state;
          vld_p1    <= 1'b1;
        end
      end
    end
  end

  // Stage p1: candidate presented to the event register
  assign newp_rest  = newp_p1 & 16'(newp_p1 - 16'd1);
  assign cand_vld   = vld_p1 && (newp_p1 != '0);
  assign cand_code  = lowest_key(newp_p1);
  assign cand_multi = cand_vld && (newp_rest != '0);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sequencer, column synchronizer, debouncer and a
// one-deep press-event register with valid/ready handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ROWS-1:0]       row_out,
  input  logic [COLS-1:0]       col_in,
  output logic [KEYS-1:0]       key_state,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_ready,
  output logic                  key_lost
);

  localparam int                CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [COLS-1:0]       col_s1, col_s2;
  logic [1:0]            row_idx;
  logic [CNT_W-1:0]      slot_cnt;
  logic                  slot_last;
  logic [KEYS-1:0]       snapshot;
  logic                  frame_done;
  logic                  cand_vld;
  logic [KEY_CODE_W-1:0] cand_code;
  logic                  cand_multi;
  logic                  hs;

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign row_out   = ~(ROWS'(1) << row_idx);

  // Stage p0: synchronize columns, sequence rows, sample at end of each slot
  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1     <= '1;
      col_s2     <= '1;
      row_idx    <= '0;
      slot_cnt   <= '0;
      snapshot   <= '0;
      frame_done <= 1'b0;
    end else begin
      col_s1     <= col_in;
      col_s2     <= col_s1;
      frame_done <= slot_last && (row_idx == 2'd3);
      if (slot_last) begin
        slot_cnt                       <= '0;
        row_idx                        <= row_idx + 2'd1;
        snapshot[row_idx*COLS +: COLS] <= ~col_s2;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .frame_done(frame_done),
    .snapshot  (snapshot),
    .key_state (key_state),
    .cand_vld  (cand_vld),
    .cand_code (cand_code),
    .cand_multi(cand_multi)
  );

  assign hs = key_valid && key_ready;

  // Stage p2: one-deep event register; a full, unaccepted slot keeps its event
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_lost  <= 1'b0;
    end else begin
      key_lost <= cand_multi;
      if (cand_vld) begin
        if (!key_valid || hs) begin
          key_code  <= cand_code;
          key_valid <= 1'b1;
        end else begin
          key_lost <= 1'b1;
        end
      end else if (hs) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural key matrix and an
// event scoreboard popped on each accepted handshake.
module tb_keypad_scanner;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        key_lost;

  logic [15:0] keys;
  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cnt  = 0;
  int          lost_cnt = 0;
  int          vld_cycles = 0;
  int          exp_q[$];

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_out  (row_out),
    .col_in   (col_in),
    .key_state(key_state),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_lost (key_lost)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (key_lost) lost_cnt++;
      if (key_valid) vld_cycles++;
      if (key_valid && key_ready) begin
        int exp_code;
        exp_code = (exp_q.size() != 0) ? exp_q.pop_front() : 'hFF;
        acc_cnt++;
        check_eq("event_code", 32'(key_code), 32'(exp_code));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame_start();
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      prev = row_out;
      step(1);
      if (prev == 4'b0111 && row_out == 4'b1110) found = 1'b1;
    end
    check_eq("frame_align", 32'(found), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 300 && !key_valid; k++) step(1);
    check_eq(tag, 32'(key_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lost0;
    logic found;
    rst       = 1'b1;
    keys      = '0;
    key_ready = 1'b1;
    step(3);
    check_eq("rst_row_out", 32'(row_out), 32'hE);
    check_eq("rst_key_state", 32'(key_state), 32'h0);
    check_eq("rst_key_valid", 32'(key_valid), 32'h0);
    check_eq("rst_key_code", 32'(key_code), 32'h0);
    check_eq("rst_key_lost", 32'(key_lost), 32'h0);
    rst = 1'b0;

    // idle scan: four clocks per row
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("scan_row_%0d", i), 32'(row_out), 32'(~(4'b0001 << (i / 4)) & 4'hF));
      step(1);
    end
    step(2 * FRAME);
    check_eq("idle_key_state", 32'(key_state), 32'h0);
    check_eq("idle_no_valid", 32'(vld_cycles), 32'd0);

    // key 6 held, then released
    exp_q.push_back(6);
    keys = 16'h0040;
    wait_valid("k6_valid_timeout");
    step(4 * FRAME);
    check_eq("k6_state", 32'(key_state), 32'h0040);
    check_eq("k6_events", 32'(acc_cnt), 32'd1);
    keys = '0;
    step(6 * FRAME);
    check_eq("k6_release_state", 32'(key_state), 32'h0);
    check_eq("k6_release_events", 32'(acc_cnt), 32'd1);

    // key 6 closed for exactly one frame
    wait_frame_start();
    keys = 16'h0040;
    step(FRAME);
    keys = '0;
    step(6 * FRAME);
    check_eq("glitch_state", 32'(key_state), 32'h0);
    check_eq("glitch_events", 32'(acc_cnt), 32'd1);

    // keys 3 and 9 in the same frame
    wait_frame_start();
    lost0 = lost_cnt;
    exp_q.push_back(3);
    keys = 16'h0208;
    wait_valid("k3k9_valid_timeout");
    step(4 * FRAME);
    check_eq("k3k9_state", 32'(key_state), 32'h0208);
    check_eq("k3k9_lost", 32'(lost_cnt - lost0), 32'd1);
    check_eq("k3k9_events", 32'(acc_cnt), 32'd2);
    keys = '0;
    step(6 * FRAME);
    check_eq("k3k9_release_state", 32'(key_state), 32'h0);

    // key 5 pending, key 12 arrives while full
    key_ready = 1'b0;
    exp_q.push_back(5);
    keys = 16'h0020;
    wait_valid("k5_valid_timeout");
    step(4 * FRAME);
    check_eq("k5_code", 32'(key_code), 32'd5);
    lost0 = lost_cnt;
    keys = 16'h1020;
    step(6 * FRAME);
    check_eq("k12_lost", 32'(lost_cnt - lost0), 32'd1);
    check_eq("k12_code_kept", 32'(key_code), 32'd5);
    check_eq("k12_valid_kept", 32'(key_valid), 32'd1);
    check_eq("k12_state", 32'(key_state), 32'h1020);
    key_ready = 1'b1;
    step(1);
    check_eq("k5_drain_valid", 32'(key_valid), 32'd0);
    check_eq("k5_events", 32'(acc_cnt), 32'd3);
    keys = '0;
    step(6 * FRAME);
    check_eq("k5_release_state", 32'(key_state), 32'h0);

    // reset mid-row-2 with an event pending
    key_ready = 1'b0;
    keys = 16'h0001;
    wait_valid("k0_valid_timeout");
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (row_out == 4'b1011) found = 1'b1;
      else step(1);
    end
    check_eq("row2_reached", 32'(found), 32'd1);
    step(1);
    rst = 1'b1;
    step(1);
    check_eq("midrst_valid", 32'(key_valid), 32'd0);
    check_eq("midrst_state", 32'(key_state), 32'h0);
    check_eq("midrst_row_out", 32'(row_out), 32'hE);
    check_eq("midrst_lost", 32'(key_lost), 32'd0);
    keys = '0;
    rst = 1'b0;
    key_ready = 1'b1;
    step(6 * FRAME);
    check_eq("post_rst_events", 32'(acc_cnt), 32'd3);
    check_eq("post_rst_state", 32'(key_state), 32'h0);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
